core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
- Round-robin arbiter that shares one memory slave port between N generated RISC-V kernel cores.
- Each core uses the valid/write/size/addr/wdata/rdata/ready request bus.
- Sits between the cores' memory ports and the single memory/peripheral slave.
- Grants one transaction at a time, forwards it unmodified, returns the slave's ready/rdata to the winner, and recovers from hung slaves with a watchdog.

Parameters:
N, 2, number of requesting cores (2..4)
TIMEOUT, 255, max BUSY cycles without s_ready before forced release; 0 disables the watchdog
TW, 16, watchdog counter width; TIMEOUT must be < 2^TW

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-high reset
m_valid  input  N  per-requester request valid
m_write  input  N  per-requester 1=write, 0=read
m_size  input  3*N  per-requester size code (0=byte, 1=half, 2=word), slice i = [3i+2:3i]
m_addr  input  32*N  per-requester byte address, slice i = [32i+31:32i]
m_wdata  input  32*N  per-requester write data
m_ready  output  N  per-requester completion strobe
m_rdata  output  32  read data broadcast to all requesters
s_valid  output  1  slave request valid
s_write  output  1  slave write
s_size  output  3  slave size code
s_addr  output  32  slave address
s_wdata  output  32  slave write data
s_rdata  input  32  slave read data, valid when s_ready=1
s_ready  input  1  slave completion strobe
gnt  output  N  one-hot current grant, 0 when not BUSY
err  output  N  sticky per-requester timeout flag

Behaviour:
- Reset: state=IDLE, rr pointer=0, grant index=0, watchdog=0, err=0.
- Reset outputs: m_ready=0, gnt=0, s_valid=0, s_write=0, s_size=0, s_addr=0, s_wdata=0, m_rdata=s_rdata gated to 0.
- Reset mid-transaction aborts it immediately with no ready to any requester.
- IDLE state: if any m_valid, pick the first set bit searching from rr pointer upward with wrap. Register it as g and go to BUSY. Otherwise stay in IDLE.
- BUSY state:
  - gnt = onehot(g).
  - s_valid/s_write/s_size/s_addr/s_wdata = slice g of m_* (combinational).
  - Watchdog increments each cycle.
- BUSY exits (checked in this order):
  (a) s_ready=1: m_ready[g]=1 in that same cycle, m_rdata=s_rdata; go to REL.
  (b) TIMEOUT!=0 and watchdog==TIMEOUT: m_ready[g]=1, m_rdata=0, s_valid forced 0 this cycle, err[g]<=1; go to REL.
  (c) m_valid[g]=0 (requester abort): no m_ready; go to REL.
- REL state: one bus-turnaround cycle. All s_*=0, gnt=0, watchdog<=0, rr pointer <= (g+1) mod N; go to IDLE.
  - The pointer also advances on abort or timeout.
- Latency: request seen in IDLE at cycle t -> s_valid at t+1. If the slave is ready at t+1, the next grant occurs no earlier than t+3 (minimum 3 cycles per transaction).
- m_ready is never asserted to a non-granted requester. At most one m_ready bit is high per cycle.
- s_ready is ignored outside BUSY.
- err bits clear only on rst.
- Simultaneous new requests during BUSY/REL are held (requesters keep valid high) and arbitrated in IDLE.
- s_ready and watchdog expiry in the same cycle: treated as normal completion, err not set.

Test Plan:
- Single write: m_valid[0]=1, write=1, size=2, addr=0x100, wdata=0x12345678; slave ready on 1st BUSY cycle -> s_valid high exactly 1 cycle with those values, m_ready[0] same cycle, gnt=01 then 00, rr=1.
- Contention: m_valid=11 from reset (both reads, addr 0x10/0x20), slave returns 0xAAAA/0xBBBB -> grant order 0 then 1; m_ready[0] with m_rdata=0xAAAA, then m_ready[1] with 0xBBBB; requester 0 re-requesting immediately is granted after 1 (order 0,1,0).
- Wait states: slave ready after 5 cycles -> s_valid/addr held stable 5 cycles, m_ready single-cycle pulse, err stays 0.
- Timeout: TIMEOUT=8, slave never ready, requester 1 -> m_ready[1] after 8 BUSY cycles, m_rdata=0, err=10, next request to requester 0 proceeds normally.
- Abort: requester 0 drops m_valid on 2nd BUSY cycle -> s_valid drops same cycle, no m_ready, REL then IDLE, rr=1.
- Reset mid-op: assert rst during BUSY with slave stalled -> all outputs 0 asynchronously, no m_ready; after release the first request is granted from rr=0.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave port between N cores.
// One transaction at a time, with a turnaround cycle and a hung-slave watchdog.
module core_bus_arbiter #(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    m_valid,
  input  logic [N-1:0]    m_write,
  input  logic [3*N-1:0]  m_size,
  input  logic [32*N-1:0] m_addr,
  input  logic [32*N-1:0] m_wdata,
  output logic [N-1:0]    m_ready,
  output logic [31:0]     m_rdata,
  output logic            s_valid,
  output logic            s_write,
  output logic [2:0]      s_size,
  output logic [31:0]     s_addr,
  output logic [31:0]     s_wdata,
  input  logic [31:0]     s_rdata,
  input  logic            s_ready,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    err
);

  localparam int unsigned GW = (N > 2) ? 2 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [N-1:0]  err_q, err_d;

  logic [GW-1:0] pick;
  logic          found;
  int unsigned   idx;

  logic [N-1:0]  g_oh;
  logic          sel_valid;
  logic          sel_write;
  logic [2:0]    sel_size;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          wd_expired;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = (32'(rr_q) + 32'(k)) % N;
      if (!found && m_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // Request fields of the granted requester.
  always_comb begin
    g_oh      = '0;
    sel_valid = 1'b0;
    sel_write = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (g_q == GW'(i)) begin
        g_oh[i]   = 1'b1;
        sel_valid = m_valid[i];
        sel_write = m_write[i];
        sel_size  = m_size[3*i +: 3];
        sel_addr  = m_addr[32*i +: 32];
        sel_wdata = m_wdata[32*i +: 32];
      end
    end
  end

  assign wd_expired = (TIMEOUT != 0) && (wd_q == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    m_ready = '0;
    m_rdata = '0;
    s_valid = 1'b0;
    s_write = 1'b0;
    s_size  = '0;
    s_addr  = '0;
    s_wdata = '0;
    gnt     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d     = pick;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        gnt     = g_oh;
        s_valid = sel_valid;
        s_write = sel_write;
        s_size  = sel_size;
        s_addr  = sel_addr;
        s_wdata = sel_wdata;
        wd_d    = wd_q + TW'(1);
        // Slave completion wins over a watchdog expiry in the same cycle.
        if (s_ready) begin
          m_ready = g_oh;
          m_rdata = s_rdata;
          state_d = S_REL;
        end else if (wd_expired) begin
          m_ready = g_oh;
          s_valid = 1'b0;
          err_d   = err_q | g_oh;
          state_d = S_REL;
        end else if (!sel_valid) begin
          state_d = S_REL;
        end
      end
      S_REL: begin
        wd_d    = '0;
        rr_d    = (g_q == GW'(N-1)) ? '0 : g_q + GW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter (N=2, TIMEOUT=8) with a completion scoreboard.
module tb_core_bus_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_write;
  logic [3*N-1:0]  m_size;
  logic [32*N-1:0] m_addr;
  logic [32*N-1:0] m_wdata;
  logic [N-1:0]    m_ready;
  logic [31:0]     m_rdata;
  logic            s_valid;
  logic            s_write;
  logic [2:0]      s_size;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata;
  logic            s_ready;
  logic [N-1:0]    gnt;
  logic [N-1:0]    err;

  core_bus_arbiter #(.N(N), .TIMEOUT(TO), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_write(m_write), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_write(s_write), .s_size(s_size),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .gnt(gnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    m_valid[i]         = v;
    m_write[i]         = w;
    m_size[3*i +: 3]   = sz;
    m_addr[32*i +: 32] = a;
    m_wdata[32*i +: 32] = d;
  endtask

  // Every completion strobe must match the oldest expected completion.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (|m_ready)) begin
      chk("ready_onehot", 32'($countones(m_ready)), 32'd1);
      chk("ready_in_gnt", 32'(m_ready & ~gnt), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_ready", 32'(m_ready), 32'd0);
      end else begin
        e = q.pop_front();
        chk("ready_idx", 32'(m_ready), 32'(1) << e.idx);
        chk("ready_rdata", m_rdata, e.rdata);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    m_valid = '0;
    m_write = '0;
    m_size  = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ready = 1'b0;
    s_rdata = 32'hDEAD_BEEF;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sval", 32'(s_valid), 32'd0);
    chk("rst_mready", 32'(m_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_saddr", s_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single write, slave ready on first BUSY cycle
    set_req(0, 1'b1, 1'b1, 3'd2, 32'h100, 32'h1234_5678);
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h0;
    q.push_back('{0, 32'h0});
    @(negedge clk);
    chk("w_sval", 32'(s_valid), 32'd1);
    chk("w_swrite", 32'(s_write), 32'd1);
    chk("w_ssize", 32'(s_size), 32'd2);
    chk("w_saddr", s_addr, 32'h100);
    chk("w_swdata", s_wdata, 32'h1234_5678);
    chk("w_gnt", 32'(gnt), 32'b01);
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    @(negedge clk);
    chk("w_rel_gnt", 32'(gnt), 32'd0);
    chk("w_rel_sval", 32'(s_valid), 32'd0);
    chk("w_rel_mready", 32'(m_ready), 32'd0);
    tick();
    // Pointer moved to 1: both requesting, 1 wins
    set_req(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
    tick();
    @(negedge clk);
    chk("rr_after_write", 32'(gnt), 32'b10);
    tick();
    m_valid = '0;
    tick();
    tick();

    // Contention from reset: order 0, 1, 0
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    m_valid = 2'b11;
    tick();
    s_ready = 1'b1;
    s_rdata = 32'hAAAA;
    q.push_back('{0, 32'hAAAA});
    @(negedge clk);
    chk("c0_gnt", 32'(gnt), 32'b01);
    chk("c0_saddr", s_addr, 32'h10);
    tick();
    s_ready = 1'b0;
    tick();
    tick();
    s_ready = 1'b1;
    s_rdata = 32'hBBBB;
    q.push_back('{1, 32'hBBBB});
    @(negedge clk);
    chk("c1_gnt", 32'(gnt), 32'b10);
    chk("c1_saddr", s_addr, 32'h20);
    tick();
    s_ready = 1'b0;
    m_valid[1] = 1'b0;
    tick();
    tick();
    s_ready = 1'b1;
    s_rdata = 32'hCCCC;
    q.push_back('{0, 32'hCCCC});
    @(negedge clk);
    chk("c2_gnt", 32'(gnt), 32'b01);
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();
    tick();

    // Wait states: five stalled cycles then completion
    set_req(1, 1'b1, 1'b0, 3'd1, 32'h300, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ws_sval", 32'(s_valid), 32'd1);
      chk("ws_saddr", s_addr, 32'h300);
      chk("ws_mready", 32'(m_ready), 32'd0);
      tick();
    end
    s_ready = 1'b1;
    s_rdata = 32'h55AA;
    q.push_back('{1, 32'h55AA});
    @(negedge clk);
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    @(negedge clk);
    chk("ws_pulse", 32'(m_ready), 32'd0);
    chk("ws_err", 32'(err), 32'd0);
    tick();

    // Timeout on requester 1
    s_rdata = 32'hFFFF_FFFF;
    set_req(1, 1'b1, 1'b0, 3'd2, 32'h400, 32'h0);
    tick();
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk);
      chk("to_sval", 32'(s_valid), 32'd1);
      tick();
    end
    q.push_back('{1, 32'h0});
    @(negedge clk);
    chk("to_sval_forced", 32'(s_valid), 32'd0);
    tick();
    m_valid = '0;
    @(negedge clk);
    chk("to_err", 32'(err), 32'b10);
    tick();
    set_req(0, 1'b1, 1'b0, 3'd2, 32'h500, 32'h0);
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h1234;
    q.push_back('{0, 32'h1234});
    @(negedge clk);
    chk("to_next_gnt", 32'(gnt), 32'b01);
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();

    // Abort: requester 0 drops valid on second BUSY cycle
    m_valid = 2'b01;
    tick();
    @(negedge clk);
    chk("ab_sval1", 32'(s_valid), 32'd1);
    tick();
    m_valid = '0;
    @(negedge clk);
    chk("ab_sval2", 32'(s_valid), 32'd0);
    chk("ab_gnt", 32'(gnt), 32'b01);
    chk("ab_mready", 32'(m_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("ab_rel_gnt", 32'(gnt), 32'd0);
    tick();
    m_valid = 2'b11;
    tick();
    @(negedge clk);
    chk("ab_rr", 32'(gnt), 32'b10);

    // Reset mid-transaction with the slave stalled
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mr_sval", 32'(s_valid), 32'd0);
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_mready", 32'(m_ready), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    s_ready = 1'b1;
    @(negedge clk);
    chk("mr_hold_mready", 32'(m_ready), 32'd0);
    s_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h7777;
    q.push_back('{0, 32'h7777});
    @(negedge clk);
    chk("mr_first_gnt", 32'(gnt), 32'b01);
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();
    tick();

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
